// File: rtl/uart_char_rx.sv
// 8N1 serial receiver feeding the character display: mid-bit sampling, CR->LF mapping,
// NUL suppression and a saturating framing-error counter.
module uart_char_rx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter bit          CR_TO_LF     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] char_data,
  output logic       data_valid,
  output logic       framing_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state, state_d;
  logic [1:0]  sync;
  logic        rx_s;
  logic [15:0] bit_cnt, bit_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        emit, ferr;

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    emit      = 1'b0;
    ferr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit; a high here was a glitch.
        if (bit_cnt == HALF_M1) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_d        = '0;
          shreg_d[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rx_s) begin
            emit    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end
      BREAK: begin
        // Hold here for the whole low period so a break counts as one error.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync        <= 2'b11;
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      char_data   <= 8'h20;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      sync        <= {sync[0], rx};
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      bit_idx     <= bit_idx_d;
      shreg       <= shreg_d;
      data_valid  <= emit && (shreg != 8'h00);
      framing_err <= ferr;
      if (emit && (shreg != 8'h00))
        char_data <= (CR_TO_LF && (shreg == 8'h0D)) ? 8'h0A : shreg;
      if (ferr && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_char_rx.sv
// Bench for uart_char_rx: two instances (CR_TO_LF=1 and 0) share one serial line and are
// compared every cycle against a frame-level event model built from the transmitted bytes.
module tb_uart_char_rx;

  localparam int C    = 8;
  localparam int HALF = C / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;

  logic [7:0] a_char, b_char, a_err, b_err;
  logic       a_dv, b_dv, a_fe, b_fe, a_busy, b_busy;

  uart_char_rx #(.CLKS_PER_BIT(C), .CR_TO_LF(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rx(rx),
    .char_data(a_char), .data_valid(a_dv), .framing_err(a_fe),
    .err_cnt(a_err), .busy(a_busy)
  );

  uart_char_rx #(.CLKS_PER_BIT(C), .CR_TO_LF(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rx(rx),
    .char_data(b_char), .data_valid(b_dv), .framing_err(b_fe),
    .err_cnt(b_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame outcome due on a given cycle, and the span over which the receiver is busy.
  typedef struct {
    int         at;
    bit         good;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int from;
    int upto;
  } iv_t;

  ev_t evq[$];
  iv_t ivq[$];

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] exp_char_a = 8'h20;
  logic [7:0] exp_char_b = 8'h20;
  logic [7:0] exp_err    = 8'h00;
  int strobes_a = 0, strobes_b = 0, fe_cnt = 0;
  int last_dv_cyc = -1;
  int frame_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] map_byte(input logic [7:0] b, input bit cr_to_lf);
    return (cr_to_lf && b == 8'h0D) ? 8'h0A : b;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit  e_dv, e_fe, e_busy;
    ev_t ev;
    e_dv   = 1'b0;
    e_fe   = 1'b0;
    e_busy = 1'b0;
    if (!rst) begin
      exp_char_a = 8'h20;
      exp_char_b = 8'h20;
      exp_err    = 8'h00;
      evq.delete();
      ivq.delete();
    end else begin
      while (evq.size() > 0 && evq[0].at < cyc) void'(evq.pop_front());
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (ev.good) begin
          if (ev.data != 8'h00) begin
            e_dv       = 1'b1;
            exp_char_a = map_byte(ev.data, 1'b1);
            exp_char_b = map_byte(ev.data, 1'b0);
          end
        end else begin
          e_fe = 1'b1;
          if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        end
      end
      while (ivq.size() > 0 && ivq[0].upto <= cyc) void'(ivq.pop_front());
      e_busy = (ivq.size() > 0) && (ivq[0].from <= cyc);
    end
    check("a_data_valid", a_dv, e_dv);
    check("b_data_valid", b_dv, e_dv);
    check("a_char_data", a_char, exp_char_a);
    check("b_char_data", b_char, exp_char_b);
    check("a_framing_err", a_fe, e_fe);
    check("b_framing_err", b_fe, e_fe);
    check("a_err_cnt", a_err, exp_err);
    check("b_err_cnt", b_err, exp_err);
    check("a_busy", a_busy, e_busy);
    check("b_busy", b_busy, e_busy);
    if (a_dv) begin
      strobes_a++;
      last_dv_cyc = cyc;
    end
    if (b_dv) strobes_b++;
    if (a_fe) fe_cnt++;
  end

  // Called at a negedge; drives one frame and leaves rx high for idle_after cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int extra_low_bits, input int idle_after);
    ev_t ev;
    iv_t iv;
    frame_start = cyc;
    ev.at   = frame_start + 3 + HALF + 9 * C;
    ev.good = stop_ok;
    ev.data = b;
    evq.push_back(ev);
    iv.from = frame_start + 3;
    iv.upto = stop_ok ? ev.at : frame_start + 10 * C + extra_low_bits * C + 3;
    ivq.push_back(iv);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_ok;
    repeat (C) @(negedge clk);
    if (!stop_ok) repeat (extra_low_bits * C) @(negedge clk);
    rx = 1'b1;
    repeat (idle_after) @(negedge clk);
  endtask

  initial begin
    int   s0;
    int   f0;
    iv_t  iv;
    logic [7:0] ab;

    repeat (3) @(negedge clk);
    check("reset_char", a_char, 8'h20);
    check("reset_busy", a_busy, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte and strobe latency from the synchronised falling edge.
    s0 = strobes_a;
    send_frame(8'h41, 1'b1, 0, 20);
    check("byte_41_count", strobes_a - s0, 1);
    check("byte_41_char", a_char, 8'h41);
    check("byte_41_latency", last_dv_cyc - (frame_start + 2), 77);
    check("byte_41_busy", a_busy, 1'b0);

    // CR, NUL, 'z' back to back.
    s0 = strobes_a;
    send_frame(8'h0D, 1'b1, 0, 0);
    check("cr_lf_a", a_char, 8'h0A);
    check("cr_raw_b", b_char, 8'h0D);
    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'h7A, 1'b1, 0, 20);
    check("crnul_strobes", strobes_a - s0, 2);
    check("crnul_last", a_char, 8'h7A);

    // Short low glitch.
    s0 = strobes_a;
    iv.from = cyc + 3;
    iv.upto = cyc + 3 + HALF;
    ivq.push_back(iv);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_strobes", strobes_a - s0, 0);
    check("glitch_err", a_err, 8'd0);
    check("glitch_busy", a_busy, 1'b0);

    // Bad stop followed by a 40-bit break, then a good frame.
    s0 = strobes_a;
    f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 40, 10);
    check("break_fe_pulses", fe_cnt - f0, 1);
    check("break_err", a_err, 8'd1);
    check("break_strobes", strobes_a - s0, 0);
    send_frame(8'h31, 1'b1, 0, 20);
    check("after_break_char", a_char, 8'h31);

    // Error counter saturation.
    f0 = fe_cnt;
    for (int i = 0; i < 300; i++) send_frame(8'hA5, 1'b0, 0, 4);
    check("sat_fe_pulses", fe_cnt - f0, 300);
    check("sat_err_a", a_err, 8'd255);
    check("sat_err_b", b_err, 8'd255);

    // Asynchronous reset during data bit 4.
    ab = 8'h5A;
    iv.from = cyc + 3;
    iv.upto = cyc + 100000;
    ivq.push_back(iv);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx = ab[i];
      repeat (C) @(negedge clk);
    end
    check("pre_reset_busy", a_busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_char", a_char, 8'h20);
    check("async_rst_valid", a_dv, 1'b0);
    check("async_rst_fe", a_fe, 1'b0);
    check("async_rst_err", a_err, 8'd0);
    check("async_rst_busy", a_busy, 1'b0);
    rx = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    s0 = strobes_a;
    send_frame(8'h42, 1'b1, 0, 20);
    check("post_reset_strobes", strobes_a - s0, 1);
    check("post_reset_char", a_char, 8'h42);

    check("pending_events", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_char_rx.md
Name: uart_char_rx

Overview:
- Serial front end for the character display path.
- Receives 8N1 asynchronous serial bytes on a single input line and strobes each accepted byte onto the display's char_data/data_valid interface.
- Normalises line endings (CR becomes LF), drops NUL bytes, and counts framing errors.
- Sits directly upstream of the VGA character display and drives its char_data and data_valid inputs one-to-one.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per serial bit (25 MHz / 115200); legal range is 4 to 65535.
- CR_TO_LF, 1, when 1, received 0x0D is emitted as 0x0A; when 0, it passes unchanged.

Ports:
- clk  in  1  system/pixel clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  serial line; idles high; asynchronous to clk.
- char_data  out  8  last emitted byte; held stable between strobes.
- data_valid  out  1  one-cycle strobe; char_data is valid in the same cycle.
- framing_err  out  1  one-cycle pulse when a stop bit samples low.
- err_cnt  out  8  saturating count of framing errors.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: char_data=0x20, data_valid=0, framing_err=0, err_cnt=0, busy=0.
  - Internal: FSM=IDLE, counters=0, synchroniser flops=1.
  - Reset mid-frame abandons the frame; no strobe is produced.
- Input synchronisation:
  - rx passes through two flops to give rx_s.
  - All decisions use rx_s only; rx is never sampled directly.
- Counters:
  - bit_cnt is 16 bits wide and counts 0..CLKS_PER_BIT-1.
  - bit_idx is 3 bits wide and holds the data bit index.
  - HALF = CLKS_PER_BIT/2, using integer division.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s==0, go to START with bit_cnt=0.
  - START: increment bit_cnt. When bit_cnt==HALF-1, check rx_s.
    - rx_s==0: go to DATA with bit_cnt=0, bit_idx=0.
    - rx_s==1: treat as a glitch and return to IDLE. Nothing is emitted.
  - DATA: when bit_cnt==CLKS_PER_BIT-1, sample rx_s into shreg[bit_idx] (LSB first) and clear bit_cnt.
    - After bit_idx==7 is sampled, go to STOP.
    - Otherwise, bit_idx increments.
  - STOP: when bit_cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: go to IDLE and emit the byte (see Emit).
    - rx_s==0: pulse framing_err. err_cnt increments, saturating at 255. Go to BREAK. The byte is discarded.
  - BREAK: wait until rx_s==1, then go to IDLE. A long low (break) line therefore counts exactly one error and never retriggers.
- Emit (the cycle after the stop-bit sample):
  - 0x00: dropped; no strobe.
  - 0x0D with CR_TO_LF=1: data_valid=1 with char_data=0x0A.
  - Any other byte: data_valid=1 with char_data set to that byte.
  - data_valid is never high on two consecutive cycles.
  - char_data updates only on a strobe.
- Back-to-back frames: a start edge arriving the cycle IDLE is re-entered is accepted with no dead time.
- Latency: the strobe occurs HALF + 9*CLKS_PER_BIT + 1 cycles after rx_s first goes low, measured to the data_valid cycle.
- busy goes high the cycle after IDLE is left and low in the cycle IDLE is re-entered.
- Tolerance: frames with baud error up to ±2% must decode correctly.

Test Plan:
- Byte decode: CLKS_PER_BIT=8; send 0x41 (8N1, LSB first).
  - data_valid pulses exactly once with char_data=0x41.
  - The pulse lands exactly 77 cycles after rx_s falls.
  - busy returns to 0.
- Line endings and NUL: CR_TO_LF=1; send 0x0D, 0x00, 0x7A back-to-back with no idle gap.
  - Exactly two strobes: char_data=0x0A, then 0x7A.
  - CR_TO_LF=0 run: 0x0D is emitted as 0x0D.
- Glitch rejection: drive rx low for 3 cycles, then high.
  - FSM returns to IDLE; no data_valid, no framing_err, err_cnt=0.
- Framing and break:
  - Send 0x55 with a low stop bit, then hold rx low for 40 bit times, then release.
  - Expected: one framing_err pulse, err_cnt=1, no data_valid.
  - A following valid 0x31 frame yields char_data=0x31.
- Saturation: send 300 frames with bad stop bits.
  - err_cnt reaches 255 and stays there; framing_err pulses on every frame.
- Async reset mid-frame: assert rst=0 during DATA bit 4, release, then send 0x42.
  - During reset, outputs read 0x20/0/0/0/0 immediately, before any clock edge.
  - After release, the only strobe is 0x42.
